// File: rtl/seq_sub.sv
// seq_sub: digit-serial unsigned subtractor, diff = a - b with borrow-out.
// One DIGITWIDTH slice is processed per clock, LSB first, behind a
// start/busy/done handshake. Results are held until the next completion.
// Optional feature macro: SEQ_SUB_SAT_EN (saturate diff at zero on borrow).
module seq_sub #(
    parameter int DATAWIDTH  = 8,
    parameter int DIGITWIDTH = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] diff,
    output logic                 borrow
);

    localparam int N  = DATAWIDTH / DIGITWIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q,  state_d;
    logic [DATAWIDTH-1:0]  a_q,      a_d;
    logic [DATAWIDTH-1:0]  b_q,      b_d;
    logic [DATAWIDTH-1:0]  work_q,   work_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic                  bin_q,    bin_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic [DATAWIDTH-1:0]  diff_q,   diff_d;
    logic                  borrow_q, borrow_d;

    logic [DIGITWIDTH:0]   dig_s;
    logic [DATAWIDTH-1:0]  shifted_s;

    // Subtract the current low-order digit of the working operands with borrow-in.
    always_comb begin
        dig_s     = {1'b0, a_q[DIGITWIDTH-1:0]}
                  - {1'b0, b_q[DIGITWIDTH-1:0]}
                  - {{DIGITWIDTH{1'b0}}, bin_q};
        shifted_s = (work_q >> DIGITWIDTH)
                  | (DATAWIDTH'(dig_s[DIGITWIDTH-1:0]) << (DATAWIDTH - DIGITWIDTH));
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Accept new operands; the previous result stays visible.
                    a_d     = a;
                    b_d     = b;
                    work_d  = {DATAWIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    bin_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Consume one digit; operands shift right so the next digit is at bit 0.
                a_d    = a_q >> DIGITWIDTH;
                b_d    = b_q >> DIGITWIDTH;
                work_d = shifted_s;
                bin_d  = dig_s[DIGITWIDTH];
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d    = {CW{1'b0}};
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    borrow_d = dig_s[DIGITWIDTH];
`ifdef SEQ_SUB_SAT_EN
                    if (dig_s[DIGITWIDTH]) begin
                        diff_d = {DATAWIDTH{1'b0}};
                    end else begin
                        diff_d = shifted_s;
                    end
`else
                    diff_d   = shifted_s;
`endif
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything immediately.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= {DATAWIDTH{1'b0}};
            b_q      <= {DATAWIDTH{1'b0}};
            work_q   <= {DATAWIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= {DATAWIDTH{1'b0}};
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_seq_sub.sv
// Directed self-checking bench for seq_sub (DATAWIDTH=8, DIGITWIDTH=2, N=4).
module tb_seq_sub;

    logic       Clk;
    logic       Rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    int checks   = 0;
    int failures = 0;

    logic [7:0] last_diff;
    logic       last_borrow;

    seq_sub #(.DATAWIDTH(8), .DIGITWIDTH(2)) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One complete operation with start pulsed for a single cycle.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_d, input logic exp_b);
        a = av;
        b = bv;
        start = 1'b1;
        step();                      // edge k: accepted
        start = 1'b0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        chk({tag, "_done0"}, 32'(done), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();                  // edges k+1..k+3
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_done_run"}, 32'(done), 32'd0);
            chk({tag, "_diff_hold"}, 32'(diff), 32'(last_diff));
        end
        step();                      // edge k+4: enter DONE
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
        chk({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
        last_diff   = exp_d;
        last_borrow = exp_b;
        step();                      // back to IDLE
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_diff_keep"}, 32'(diff), 32'(exp_d));
    endtask

    initial begin
        Rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        last_diff = 8'h00;
        last_borrow = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        Rst_n = 1'b1;
        step();

        // 1. basic subtraction
        run_op("t1", 8'h35, 8'h12, 8'h23, 1'b0);

        // 2. borrow case
`ifdef SEQ_SUB_SAT_EN
        run_op("t2", 8'h10, 8'h20, 8'h00, 1'b1);
`else
        run_op("t2", 8'h10, 8'h20, 8'hF0, 1'b1);
`endif

        // 3. wrap boundaries
`ifdef SEQ_SUB_SAT_EN
        run_op("t3a", 8'h00, 8'h01, 8'h00, 1'b1);
`else
        run_op("t3a", 8'h00, 8'h01, 8'hFF, 1'b1);
`endif
        run_op("t3b", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("t3c", 8'hA5, 8'h5A, 8'h4B, 1'b0);

        // 4. start in RUN ignored, captured operands unaffected by input changes
        a = 8'h09;
        b = 8'h03;
        start = 1'b1;
        step();                      // edge k
        a = 8'h77;
        b = 8'h11;
        step();                      // edge k+1, start still high in RUN
        chk("t4_busy", 32'(busy), 32'd1);
        a = 8'h55;
        b = 8'h44;
        step();                      // edge k+2
        step();                      // edge k+3
        start = 1'b0;
        chk("t4_nodone", 32'(done), 32'd0);
        step();                      // edge k+4
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_diff", 32'(diff), 32'h06);
        chk("t4_borrow", 32'(borrow), 32'd0);
        last_diff = 8'h06;
        last_borrow = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t4_single_done", 32'(done), 32'd0);
            chk("t4_idle_busy", 32'(busy), 32'd0);
        end

        // 5. back-to-back issue with start held high
        a = 8'h40;
        b = 8'h08;
        start = 1'b1;
        step();                      // edge k
        chk("t5_busy0", 32'(busy), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            step();
            if ((i % 5) == 4) begin
                chk("t5_done", 32'(done), 32'd1);
                chk("t5_busy_low", 32'(busy), 32'd0);
                chk("t5_diff", 32'(diff), 32'h38);
            end else begin
                chk("t5_nodone", 32'(done), 32'd0);
                chk("t5_busy_high", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
        end
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_done", 32'(done), 32'd0);
        last_diff = 8'h38;
        last_borrow = 1'b0;

        // 6. reset in the middle of RUN
        a = 8'h50;
        b = 8'h10;
        start = 1'b1;
        step();                      // edge k, accepted
        start = 1'b0;
        step();                      // cycle 1
        step();                      // cycle 2
        #3;
        Rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_diff", 32'(diff), 32'd0);
        chk("t6_borrow", 32'(borrow), 32'd0);
        #2;
        Rst_n = 1'b1;
        last_diff = 8'h00;
        last_borrow = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_no_done", 32'(done), 32'd0);
            chk("t6_no_busy", 32'(busy), 32'd0);
        end
        run_op("t6_after", 8'h50, 8'h10, 8'h40, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
